// File: rtl/jace_kbd_pkg.sv
// Shared types and constants for the Jupiter ACE PS/2 keyboard front end.
package jace_kbd_pkg;
  typedef enum logic [1:0] {RX_IDLE, RX_DATA, RX_PARITY, RX_STOP} rx_state_t;

  localparam logic [7:0] PFX_EXT = 8'hE0;
  localparam logic [7:0] PFX_BRK = 8'hF0;
  localparam int ROW_W = 3;
  localparam int COL_W = 3;

  // Keyboard status/ack bytes that only resynchronise the prefix state.
  function automatic logic is_ignored(input logic [7:0] b);
    return (b == 8'hAA) || (b == 8'hFA) || (b == 8'hEE) ||
           (b == 8'hFE) || (b == 8'hE1);
  endfunction
endpackage

// File: rtl/jace_ps2_scanmap.sv
// Set-2 scancode to Jupiter ACE 8x5 matrix position lookup (combinational).
module jace_ps2_scanmap
  import jace_kbd_pkg::*;
(
  input  logic [7:0]       code,
  input  logic             ext,
  output logic             hit,
  output logic [ROW_W-1:0] row,
  output logic [COL_W-1:0] col
);
  always_comb begin
    hit = 1'b1;
    row = '0;
    col = '0;
    case ({ext, code})
      9'h012, 9'h059: {row, col} = {3'd0, 3'd0};
      9'h014, 9'h114: {row, col} = {3'd0, 3'd1};
      9'h01A: {row, col} = {3'd0, 3'd2};
      9'h022: {row, col} = {3'd0, 3'd3};
      9'h021: {row, col} = {3'd0, 3'd4};
      9'h01C: {row, col} = {3'd1, 3'd0};
      9'h01B: {row, col} = {3'd1, 3'd1};
      9'h023: {row, col} = {3'd1, 3'd2};
      9'h02B: {row, col} = {3'd1, 3'd3};
      9'h034: {row, col} = {3'd1, 3'd4};
      9'h015: {row, col} = {3'd2, 3'd0};
      9'h01D: {row, col} = {3'd2, 3'd1};
      9'h024: {row, col} = {3'd2, 3'd2};
      9'h02D: {row, col} = {3'd2, 3'd3};
      9'h02C: {row, col} = {3'd2, 3'd4};
      9'h016: {row, col} = {3'd3, 3'd0};
      9'h01E: {row, col} = {3'd3, 3'd1};
      9'h026: {row, col} = {3'd3, 3'd2};
      9'h025: {row, col} = {3'd3, 3'd3};
      9'h02E: {row, col} = {3'd3, 3'd4};
      9'h045: {row, col} = {3'd4, 3'd0};
      9'h046: {row, col} = {3'd4, 3'd1};
      9'h03E: {row, col} = {3'd4, 3'd2};
      9'h03D: {row, col} = {3'd4, 3'd3};
      9'h036: {row, col} = {3'd4, 3'd4};
      9'h04D: {row, col} = {3'd5, 3'd0};
      9'h044: {row, col} = {3'd5, 3'd1};
      9'h043: {row, col} = {3'd5, 3'd2};
      9'h03C: {row, col} = {3'd5, 3'd3};
      9'h035: {row, col} = {3'd5, 3'd4};
      9'h05A, 9'h15A: {row, col} = {3'd6, 3'd0};
      9'h04B: {row, col} = {3'd6, 3'd1};
      9'h042: {row, col} = {3'd6, 3'd2};
      9'h03B: {row, col} = {3'd6, 3'd3};
      9'h033: {row, col} = {3'd6, 3'd4};
      9'h029: {row, col} = {3'd7, 3'd0};
      9'h03A: {row, col} = {3'd7, 3'd1};
      9'h031: {row, col} = {3'd7, 3'd2};
      9'h032: {row, col} = {3'd7, 3'd3};
      9'h02A: {row, col} = {3'd7, 3'd4};
      default: hit = 1'b0;
    endcase
  end
endmodule

// File: rtl/jace_ps2_keyboard.sv
// PS/2 set-2 receiver feeding an 8x5 pressed-key matrix answered by the CPU row scan.
module jace_ps2_keyboard
  import jace_kbd_pkg::*;
#(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 13000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  input  logic [7:0] filas,
  output logic [4:0] columnas,
  output logic       key_strobe,
  output logic       parity_err
);
  localparam int FW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [1:0] raw, filt;
  assign raw = {ps2_data, ps2_clk};

  // Lines idle high, so sync and filter reset to 1 to avoid a phantom edge.
  for (genvar i = 0; i < 2; i++) begin : g_cond
    logic [1:0]    sync;
    logic [FW-1:0] cnt;
    logic          f;
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        sync <= 2'b11;
        cnt  <= '0;
        f    <= 1'b1;
      end else begin
        sync <= {sync[0], raw[i]};
        if (sync[1] == f) cnt <= '0;
        else if (cnt == FW'(FILTER_LEN - 1)) begin
          f   <= sync[1];
          cnt <= '0;
        end else cnt <= cnt + 1'b1;
      end
    end
    assign filt[i] = f;
  end

  logic fclk_d, fall, fdat;
  assign fdat = filt[1];
  assign fall = fclk_d & ~filt[0];

  rx_state_t     state;
  logic [2:0]    bitcnt;
  logic [7:0]    shreg;
  logic          par, byte_valid;
  logic [TW-1:0] tcnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fclk_d     <= 1'b1;
      state      <= RX_IDLE;
      bitcnt     <= '0;
      shreg      <= '0;
      par        <= 1'b0;
      tcnt       <= '0;
      byte_valid <= 1'b0;
      parity_err <= 1'b0;
    end else begin
      fclk_d     <= filt[0];
      byte_valid <= 1'b0;
      parity_err <= 1'b0;
      if (state == RX_IDLE || fall) tcnt <= '0;
      else                          tcnt <= tcnt + 1'b1;
      case (state)
        RX_IDLE:   if (fall && !fdat) begin
                     state  <= RX_DATA;
                     bitcnt <= '0;
                   end
        RX_DATA:   if (fall) begin
                     shreg  <= {fdat, shreg[7:1]};
                     bitcnt <= bitcnt + 1'b1;
                     if (bitcnt == 3'd7) state <= RX_PARITY;
                   end
        RX_PARITY: if (fall) begin
                     par   <= fdat;
                     state <= RX_STOP;
                   end
        RX_STOP:   if (fall) begin
                     if (fdat && ^{shreg, par}) byte_valid <= 1'b1;
                     else                       parity_err <= 1'b1;
                     state <= RX_IDLE;
                   end
        default:   state <= RX_IDLE;
      endcase
      // A stalled frame is silently dropped.
      if (state != RX_IDLE && !fall && tcnt == TW'(TIMEOUT_CYCLES - 1))
        state <= RX_IDLE;
    end
  end

  logic             hit;
  logic [ROW_W-1:0] row;
  logic [COL_W-1:0] col;
  logic             ext, brk;
  logic [7:0][4:0]  matrix;

  jace_ps2_scanmap u_map (.code(shreg), .ext(ext), .hit(hit), .row(row), .col(col));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ext        <= 1'b0;
      brk        <= 1'b0;
      matrix     <= '0;
      key_strobe <= 1'b0;
    end else begin
      key_strobe <= 1'b0;
      if (parity_err) begin
        ext <= 1'b0;
        brk <= 1'b0;
      end else if (byte_valid) begin
        if (shreg == PFX_EXT)      ext <= 1'b1;
        else if (shreg == PFX_BRK) brk <= 1'b1;
        else begin
          ext <= 1'b0;
          brk <= 1'b0;
          if (!is_ignored(shreg)) begin
            key_strobe <= 1'b1;
            if (hit) matrix[row][col] <= ~brk;
          end
        end
      end
    end
  end

  always_comb begin
    columnas = '1;
    for (int r = 0; r < 8; r++)
      if (!filas[r]) columnas = columnas & ~matrix[r];
  end
endmodule

// File: tb/tb_jace_ps2_keyboard.sv
// Drives PS/2 frames into the keyboard block and checks strobes, errors and the row scan.
module tb_jace_ps2_keyboard;
  localparam int HALF = 20;

  logic       clk = 1'b0, reset_n = 1'b0, ps2_clk = 1'b1, ps2_data = 1'b1;
  logic [7:0] filas = 8'hFF;
  logic [4:0] columnas;
  logic       key_strobe, parity_err;

  int errors = 0, checks = 0;
  int strobe_cnt = 0, perr_cnt = 0, exp_strobe = 0, exp_perr = 0;
  bit [39:0] mdl = '0;
  bit m_ext = 1'b0, m_brk = 1'b0;

  logic [7:0] tbl [40] = '{
    8'h12, 8'h14, 8'h1A, 8'h22, 8'h21,  8'h1C, 8'h1B, 8'h23, 8'h2B, 8'h34,
    8'h15, 8'h1D, 8'h24, 8'h2D, 8'h2C,  8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E,
    8'h45, 8'h46, 8'h3E, 8'h3D, 8'h36,  8'h4D, 8'h44, 8'h43, 8'h3C, 8'h35,
    8'h5A, 8'h4B, 8'h42, 8'h3B, 8'h33,  8'h29, 8'h3A, 8'h31, 8'h32, 8'h2A};
  logic [7:0] misc [10] = '{8'hE0, 8'hF0, 8'hAA, 8'hFA, 8'hEE, 8'hFE, 8'hE1,
                            8'h59, 8'h00, 8'h77};

  jace_ps2_keyboard dut (
    .clk(clk), .reset_n(reset_n), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .filas(filas), .columnas(columnas), .key_strobe(key_strobe), .parity_err(parity_err));

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (key_strobe) strobe_cnt <= strobe_cnt + 1;
    if (parity_err) perr_cnt   <= perr_cnt + 1;
  end

  // Matrix bit index r*5+c for a key, or -1.
  function automatic int key_idx(bit ext, logic [7:0] code);
    if (ext) return (code == 8'h14) ? 1 : (code == 8'h5A) ? 30 : -1;
    if (code == 8'h59) return 0;
    for (int k = 0; k < 40; k++) if (tbl[k] == code) return k;
    return -1;
  endfunction

  function automatic logic [4:0] exp_cols(logic [7:0] f);
    logic [4:0] v = 5'h1F;
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 5; c++)
        if (mdl[r*5+c] && !f[r]) v[c] = 1'b0;
    return v;
  endfunction

  task automatic model_byte(input logic [7:0] b, input bit good);
    int idx;
    if (!good) begin
      exp_perr++; m_ext = 0; m_brk = 0;
    end else if (b == 8'hE0) m_ext = 1;
    else if (b == 8'hF0) m_brk = 1;
    else if (b inside {8'hAA, 8'hFA, 8'hEE, 8'hFE, 8'hE1}) begin
      m_ext = 0; m_brk = 0;
    end else begin
      idx = key_idx(m_ext, b);
      if (idx >= 0) mdl[idx] = !m_brk;
      exp_strobe++; m_ext = 0; m_brk = 0;
    end
  endtask

  task automatic send_bits(input logic [10:0] bits, input int n);
    for (int i = 0; i < n; i++) begin
      ps2_data = bits[i];
      repeat (HALF) @(posedge clk);
      ps2_clk = 1'b0;
      repeat (HALF) @(posedge clk);
      ps2_clk = 1'b1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input bit bad);
    send_bits({1'b1, (~^b) ^ bad, b, 1'b0}, 11);
    ps2_data = 1'b1;
    repeat (2*HALF) @(posedge clk);
    model_byte(b, !bad);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_cols(input string tag, input logic [7:0] f);
    filas = f;
    #1 check(tag, 32'(columnas), 32'(exp_cols(f)));
  endtask

  task automatic check_counts(input string tag);
    @(negedge clk);
    check({tag, "_strobe"}, strobe_cnt, exp_strobe);
    check({tag, "_perr"}, perr_cnt, exp_perr);
  endtask

  initial begin
    repeat (4) @(negedge clk);
    filas = 8'h00;
    #1 check("reset_cols", 32'(columnas), 32'h1F);
    check("reset_strobe", 32'(key_strobe), 0);
    check("reset_perr", 32'(parity_err), 0);
    reset_n = 1'b1;
    repeat (5) @(posedge clk);

    send_byte(8'h1C, 0);
    check_counts("a_make");
    check_cols("a_make_cols", 8'hFD);
    check("a_make_const", 32'(columnas), 32'h1E);
    send_byte(8'hF0, 0); send_byte(8'h1C, 0);
    check_counts("a_break");
    check_cols("a_break_cols", 8'hFD);
    check("a_break_total", strobe_cnt, 2);

    send_byte(8'hE0, 0); send_byte(8'h14, 0);
    check_counts("sym_make");
    check_cols("sym_make_cols", 8'hFE);
    check("sym_make_const", 32'(columnas), 32'h1D);
    send_byte(8'h14, 0); send_byte(8'hF0, 0); send_byte(8'h14, 0);
    check_counts("sym_break");
    check_cols("sym_break_cols", 8'hFE);

    send_byte(8'h16, 1);
    check_counts("bad_parity");
    check_cols("bad_parity_cols", 8'hF7);
    check("bad_parity_total", perr_cnt, 1);

    send_byte(8'h15, 0); send_byte(8'h45, 0);
    check_counts("q0");
    check_cols("q0_e3", 8'hE3);
    check_cols("q0_fb", 8'hFB);
    check_cols("q0_df", 8'hDF);

    send_bits(11'b000_0000_0000, 5);
    ps2_data = 1'b1;
    repeat (14000) @(posedge clk);
    check_counts("timeout");
    send_byte(8'h29, 0);
    check_counts("space");
    check_cols("space_cols", 8'h7F);
    check("space_const", 32'(columnas), 32'h1E);

    filas = 8'h7F;
    send_bits({2'b11, 8'h1C, 1'b0}, 4);
    reset_n = 1'b0;
    #1 check("async_reset_cols", 32'(columnas), 32'h1F);
    mdl = '0; m_ext = 0; m_brk = 0;
    ps2_clk = 1'b1; ps2_data = 1'b1;
    repeat (5) @(posedge clk);
    reset_n = 1'b1;
    repeat (200) @(posedge clk);
    check_counts("post_reset");
    send_byte(8'h1C, 0);
    check_counts("post_reset_a");
    check_cols("post_reset_cols", 8'hFD);

    for (int n = 0; n < 40; n++) begin
      logic [7:0] b;
      case ($urandom_range(0, 3))
        0, 1: b = tbl[$urandom_range(0, 39)];
        2:    b = misc[$urandom_range(0, 9)];
        default: b = 8'($urandom);
      endcase
      send_byte(b, $urandom_range(0, 7) == 0);
      check_counts("rand");
      check_cols("rand_cols", 8'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/jace_ps2_keyboard.md
Name: jace_ps2_keyboard

Overview:
- Upstream keyboard stage for the Jupiter ACE core. Receives PS/2 set-2 scancodes, keeps an 8x5 pressed-key matrix, and answers the CPU's row scan.
- The row select comes in on `filas` (CPU A15..A8). The block returns active-low `columnas`, which the glue logic reads on keyboard IN ports.
- Replaces the external matrix that currently drives `columnas`.

Parameters:
- FILTER_LEN, 8: consecutive identical samples required before the filtered PS/2 clock/data changes.
- TIMEOUT_CYCLES, 13000: clk cycles (about 2 ms at 6.5 MHz) with no PS/2 clock falling edge mid-frame before the frame is abandoned.

Ports:
- clk  in  1  system clock (same as the glue logic clock)
- reset_n  in  1  asynchronous active-low reset
- ps2_clk  in  1  raw PS/2 clock, asynchronous
- ps2_data  in  1  raw PS/2 data, asynchronous
- filas  in  8  row select, active low, bit r = row r (A8+r)
- columnas  out  5  column read, active low
- key_strobe  out  1  one-cycle pulse per accepted scancode byte
- parity_err  out  1  one-cycle pulse per rejected frame

Behaviour:
- Clocking and reset: one clock. reset_n is asynchronous and active-low.
- Reset values:
  - all matrix bits released; columnas = 5'h1F for any filas
  - key_strobe = 0, parity_err = 0
  - receiver in IDLE; ext and brk flags cleared
- Input conditioning:
  - Both PS/2 lines pass through a 2-FF synchroniser, then a FILTER_LEN-sample glitch filter.
  - A falling edge is filtered clock 1 -> 0. The filtered data bit is sampled in that same cycle.
- Receiver FSM (states IDLE, DATA, PARITY, STOP):
  - IDLE: on falling edge, if data = 0 (start bit) go to DATA with bit count 0. If data = 1, stay in IDLE.
  - DATA: shift bits in LSB first. After 8 bits go to PARITY.
  - PARITY: capture the bit and go to STOP.
  - STOP: on falling edge the frame is good if stop = 1 and data plus parity has an odd number of ones.
    - Good frame: pulse byte_valid internally the next cycle.
    - Bad frame: pulse parity_err the next cycle, clear ext and brk, discard the byte.
    - Either way, return to IDLE.
  - Timeout: in any non-IDLE state, TIMEOUT_CYCLES without a falling edge returns the FSM to IDLE, discards the partial byte, and raises no error pulse.
- Decoder, on byte_valid:
  - E0: set ext. F0: set brk. Neither updates the matrix or pulses key_strobe.
  - AA, FA, EE, FE, E1: clear both flags, no other effect.
  - Any other byte:
    - Look the byte up with ext. On a hit, set matrix[row][col] = ~brk.
    - Pulse key_strobe whether or not the lookup hits.
    - Clear ext and brk.
  - key_strobe and the matrix write happen in the same cycle, one cycle after byte_valid.
  - Release of a key that is not held leaves the bit at 0.
- Row mapping (col0..col4):
  - row0: SHIFT(12, 59), SYMSHIFT(14, E0 14), Z(1A), X(22), C(21)
  - row1: A(1C), S(1B), D(23), F(2B), G(34)
  - row2: Q(15), W(1D), E(24), R(2D), T(2C)
  - row3: 1(16), 2(1E), 3(26), 4(25), 5(2E)
  - row4: 0(45), 9(46), 8(3E), 7(3D), 6(36)
  - row5: P(4D), O(44), I(43), U(3C), Y(35)
  - row6: ENTER(5A, E0 5A), L(4B), K(42), J(3B), H(33)
  - row7: SPACE(29), M(3A), N(31), B(32), V(2A)
- Mapping rules:
  - Extended codes not listed are misses.
  - A non-extended code listed only as extended is a miss.
  - Multiple physical keys mapped to one matrix bit share that bit: the last event wins.
- Column output is combinational from the registered matrix and filas:
  - columnas[c] = ~OR over r of (matrix[r][c] & ~filas[r])
  - Several selected rows are ANDed in active-low form. filas = FF gives 1F.
- Reset mid-frame abandons the frame. No strobe or error pulse follows reset deassertion.

Decomposition:
- Package jace_kbd_pkg holds:
  - FSM state enum
  - prefix constants E0, F0
  - ignore-list bytes
  - row/column index widths
- Sub-module jace_ps2_scanmap is purely combinational.
  - Inputs: code[7:0], ext
  - Outputs: hit, row[2:0], col[2:0]
  - Holds the mapping table.
- Receiver, filter, FSM, flags and matrix stay in jace_ps2_keyboard.

Test Plan:
- Frame for 1C (A), then F0 1C at 10 kHz PS/2 clock, parity correct:
  - key_strobe pulses once per non-prefix byte (twice in total)
  - after make: filas = FD gives columnas = 1E
  - after break: columnas = 1F
- E0 14 make:
  - filas = FE gives columnas = 1D
  - a plain 14 then F0 14 releases the same bit
- Frame for 16 with a wrong parity bit:
  - parity_err pulses once, no key_strobe
  - filas = F7 gives columnas = 1F
- Q (15) and 0 (45) held, filas = E3 (rows 2, 3, 4 selected):
  - columnas = 1E
  - filas = FB gives 1E; filas = DF gives 1F
- Start bit plus 4 data bits, then 3 ms idle, then a full frame for 29:
  - the partial frame is dropped with no parity_err
  - SPACE is registered: filas = 7F gives 1E
- Assert reset_n low during the DATA state after SPACE is held:
  - columnas = 1F immediately (asynchronous)
  - no strobe or error pulse after release
  - the next full frame decodes correctly
